// File: rtl/system_sysid_pkg.sv
// Shared types and constants for the system ID checker: FSM states, sysid
// word offsets, default expected words and the data width.
package system_sysid_pkg;

   localparam int SYSID_DATA_W = 32;
   localparam int SYSID_OFS_ID = 0;
   localparam int SYSID_OFS_TS = 1;

   localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID = 32'h12345678;
   localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TS = 32'h548CB93A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID_REQ,
      ST_ID_WAIT,
      ST_TS_REQ,
      ST_TS_WAIT,
      ST_DONE
   } sysid_state_e;

   function automatic logic is_req_state(input sysid_state_e s);
      return (s == ST_ID_REQ) || (s == ST_TS_REQ);
   endfunction

   function automatic logic is_busy_state(input sysid_state_e s);
      return (s == ST_ID_REQ) || (s == ST_ID_WAIT) ||
             (s == ST_TS_REQ) || (s == ST_TS_WAIT);
   endfunction

endpackage

// File: rtl/system_sysid_chk_timer.sv
// Per-transaction watchdog: clear/enable counter that flags its terminal count
// and then saturates, so an exhausted budget stays exhausted.
module system_sysid_chk_timer #(
   parameter int TERMINAL = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int CNT_W = $clog2(TERMINAL + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

   logic [CNT_W-1:0] count_reg;
   logic             at_last;

   assign at_last  = (count_reg >= LAST);
   assign terminal = enable && at_last;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !at_last) begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them with build-time values. Define SYSID_CHECKER_TIMEOUT_EN to add a per-read watchdog.
module system_sysid_checker
   import system_sysid_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
   parameter int                      ADDR_W         = 1,
   parameter int                      AUTO_START     = 1,
   parameter int                      TIMEOUT_CYCLES = 255
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic                    avm_readdatavalid,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   output logic                    busy,
   output logic                    done,
   output logic                    id_ok,
   output logic                    ts_ok,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value,
   output logic                    timeout
);

   localparam logic [ADDR_W-1:0] ADDR_ID = ADDR_W'(SYSID_OFS_ID);
   localparam logic [ADDR_W-1:0] ADDR_TS = ADDR_W'(SYSID_OFS_TS);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
   if (ADDR_W < 1) begin : g_bad_addr_w
      $error("ADDR_W must be at least 1");
   end

   sysid_state_e            state_reg, state_next;
   logic                    auto_pending_reg;
   logic [SYSID_DATA_W-1:0] id_value_reg, ts_value_reg;
   logic                    id_match_reg, ts_match_reg;

   logic                    launch, cap_id, cap_ts, abort;
   logic                    read_c;
   logic [ADDR_W-1:0]       addr_c;
   logic                    tmo_hit;

   always_comb begin
      state_next = state_reg;
      launch     = 1'b0;
      cap_id     = 1'b0;
      cap_ts     = 1'b0;
      abort      = 1'b0;
      read_c     = 1'b0;
      addr_c     = ADDR_ID;
      case (state_reg)
         ST_IDLE: begin
            if (start || auto_pending_reg) begin
               launch     = 1'b1;
               state_next = ST_ID_REQ;
            end
         end
         ST_ID_REQ: begin
            read_c = 1'b1;
            if (!avm_waitrequest) begin
               state_next = ST_ID_WAIT;
            end else if (tmo_hit) begin
               abort      = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_ID_WAIT: begin
            // Data landing on the terminal-count cycle still counts as a good read.
            if (avm_readdatavalid) begin
               cap_id     = 1'b1;
               state_next = ST_TS_REQ;
            end else if (tmo_hit) begin
               abort      = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_TS_REQ: begin
            read_c = 1'b1;
            addr_c = ADDR_TS;
            if (!avm_waitrequest) begin
               state_next = ST_TS_WAIT;
            end else if (tmo_hit) begin
               abort      = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_TS_WAIT: begin
            if (avm_readdatavalid) begin
               cap_ts     = 1'b1;
               state_next = ST_DONE;
            end else if (tmo_hit) begin
               abort      = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               launch     = 1'b1;
               state_next = ST_ID_REQ;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         auto_pending_reg <= (AUTO_START != 0);
         id_value_reg     <= '0;
         ts_value_reg     <= '0;
         id_match_reg     <= 1'b0;
         ts_match_reg     <= 1'b0;
      end else begin
         state_reg        <= state_next;
         auto_pending_reg <= 1'b0;
         if (launch || abort) begin
            id_match_reg <= 1'b0;
            ts_match_reg <= 1'b0;
         end
         if (cap_id) begin
            id_value_reg <= avm_readdata;
            id_match_reg <= (avm_readdata == EXPECTED_ID);
         end
         if (cap_ts) begin
            ts_value_reg <= avm_readdata;
            ts_match_reg <= (avm_readdata == EXPECTED_TS);
         end
      end
   end

`ifdef SYSID_CHECKER_TIMEOUT_EN
   logic timeout_reg;
   logic tmr_clear;

   assign tmr_clear = (state_next != state_reg) && is_req_state(state_next);

   system_sysid_chk_timer #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (tmr_clear),
      .enable   (is_busy_state(state_reg)),
      .terminal (tmo_hit)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         timeout_reg <= 1'b0;
      end else if (launch) begin
         timeout_reg <= 1'b0;
      end else if (abort) begin
         timeout_reg <= 1'b1;
      end
   end

   assign timeout = timeout_reg;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   // Match flags are only meaningful once the check has finished.
   assign avm_read    = read_c;
   assign avm_address = addr_c;
   assign busy        = is_busy_state(state_reg);
   assign done        = (state_reg == ST_DONE);
   assign id_ok       = done && id_match_reg;
   assign ts_ok       = done && ts_match_reg;
   assign id_value    = id_value_reg;
   assign ts_value    = ts_value_reg;

endmodule

// File: tb/tb_system_sysid_checker.sv
// Randomized bench for system_sysid_checker: a behavioural Avalon responder with
// configurable stall/latency feeds the DUT and each check is compared with a reference model.
module tb_system_sysid_checker;

   localparam logic [31:0] GOLD_ID = 32'h12345678;
   localparam logic [31:0] GOLD_TS = 32'h548CB93A;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [0:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   system_sysid_checker #(
      .EXPECTED_ID    (GOLD_ID),
      .EXPECTED_TS    (GOLD_TS),
      .ADDR_W         (1),
      .AUTO_START     (1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_readdata      (avm_readdata),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .id_value          (id_value),
      .ts_value          (ts_value),
      .timeout           (timeout)
   );

   initial forever #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_txn    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Responder configuration and state: index 0 = ID word, 1 = timestamp word.
   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   int          stall_cfg [2];
   int          lat_cfg   [2];
   logic [31:0] rsp_word  [2];
   bit          stuck     = 1'b0;
   rsp_t        pend_q[$];
   int          stall_left = -1;
   bit          stalling   = 1'b0;
   logic [0:0]  stall_addr = '0;

   // Advance one cycle and play the slave for it; everything runs in one process.
   task automatic step();
      rsp_t r;
      @(negedge clock);
      if (!reset_n) begin
         pend_q.delete();
         stall_left        = -1;
         stalling          = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_waitrequest   = 1'b0;
         return;
      end
      if (stalling) begin
         check_eq("stall_read", avm_read, 1);
         check_eq("stall_addr", avm_address, stall_addr);
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = pend_q[0].data;
         void'(pend_q.pop_front());
      end else begin
         // Stray valid strobes only when nothing is outstanding.
         avm_readdatavalid = (pend_q.size() == 0) && ($urandom_range(3) == 0);
         avm_readdata      = $urandom();
      end
      stalling = 1'b0;
      if (avm_read) begin
         if (stuck) begin
            avm_waitrequest = 1'b1;
         end else begin
            if (stall_left < 0) stall_left = stall_cfg[avm_address];
            if (stall_left > 0) begin
               avm_waitrequest = 1'b1;
               stall_left--;
               stalling   = 1'b1;
               stall_addr = avm_address;
            end else begin
               avm_waitrequest = 1'b0;
               stall_left      = -1;
               r.due  = cyc + lat_cfg[avm_address];
               r.data = rsp_word[avm_address];
               pend_q.push_back(r);
            end
         end
      end else begin
         avm_waitrequest = 1'($urandom_range(1));
      end
   endtask

   task automatic set_cfg(input int s0, input int s1, input int l0, input int l1,
                          input logic [31:0] idw, input logic [31:0] tsw);
      stall_cfg[0] = s0; stall_cfg[1] = s1;
      lat_cfg[0]   = l0; lat_cfg[1]   = l1;
      rsp_word[0]  = idw; rsp_word[1] = tsw;
   endtask

   function automatic logic [31:0] pick_word(input logic [31:0] gold);
      case ($urandom_range(2))
         0:       return gold;
         1:       return gold ^ (32'h1 << $urandom_range(31));
         default: return $urandom();
      endcase
   endfunction

   // Called in cycle 0; launches by start or by reset release (auto start).
   task automatic run_check(input bit by_reset, input int mid_start);
      int          exp_done, got_done, hold;
      bit          leak;
      logic [31:0] idv, tsv;
      exp_done = 1 + (stall_cfg[0] + 1 + lat_cfg[0]) + (stall_cfg[1] + 1 + lat_cfg[1]);
      got_done = -1;
      leak     = 1'b0;
      if (by_reset) reset_n = 1'b1;
      else start = 1'b1;
      for (int t = 1; t <= 200; t++) begin
         step();
         start = (t == mid_start);
         if (t == 1) begin
            check_eq("launch_busy", busy, 1);
            check_eq("launch_done", done, 0);
         end
         if (busy && (id_ok || ts_ok)) leak = 1'b1;
         if (done) begin
            got_done = t;
            break;
         end
      end
      start = 1'b0;
      check_eq("done_cycle", got_done, exp_done);
      check_eq("id_value", id_value, rsp_word[0]);
      check_eq("ts_value", ts_value, rsp_word[1]);
      check_eq("id_ok", id_ok, rsp_word[0] == GOLD_ID);
      check_eq("ts_ok", ts_ok, rsp_word[1] == GOLD_TS);
      check_eq("timeout", timeout, 0);
      check_eq("flags_while_busy", leak, 0);
      idv  = id_value;
      tsv  = ts_value;
      hold = $urandom_range(4, 1);
      repeat (hold) step();
      check_eq("done_sticky", done, 1);
      check_eq("busy_after", busy, 0);
      check_eq("id_hold", id_value, idv);
      check_eq("ts_hold", ts_value, tsv);
      n_txn++;
      $display("txn %0d: id=%h ts=%h stall=%0d/%0d lat=%0d/%0d done@%0d (model %0d) id_ok=%0b ts_ok=%0b",
               n_txn, id_value, ts_value, stall_cfg[0], stall_cfg[1], lat_cfg[0], lat_cfg[1],
               got_done, exp_done, id_ok, ts_ok);
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_read"}, avm_read, 0);
      check_eq({pfx, "_addr"}, avm_address, 0);
      check_eq({pfx, "_busy"}, busy, 0);
      check_eq({pfx, "_done"}, done, 0);
      check_eq({pfx, "_id_ok"}, id_ok, 0);
      check_eq({pfx, "_ts_ok"}, ts_ok, 0);
      check_eq({pfx, "_id_value"}, id_value, 0);
      check_eq({pfx, "_ts_value"}, ts_value, 0);
      check_eq({pfx, "_timeout"}, timeout, 0);
   endtask

   task automatic reset_mid();
      bit found;
      found = 1'b0;
      start = 1'b1;
      for (int t = 0; t < 200; t++) begin
         step();
         start = 1'b0;
         if (avm_read && avm_address == 1'b1 && !avm_waitrequest) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("reach_ts_wait", found, 1);
      step();
      reset_n = 1'b0;
      step();
      check_all_zero("mid_rst");
      $display("txn: reset asserted during TS_WAIT, outputs cleared");
      run_check(1'b1, 0);
   endtask

   initial begin
      int s0, s1, l0, l1, ms, exp_d;
      reset_n           = 1'b0;
      start             = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      set_cfg(0, 0, 1, 1, GOLD_ID, GOLD_TS);
      repeat (3) step();
      check_all_zero("rst");

      run_check(1'b1, 0);
      set_cfg(0, 0, 1, 1, 32'h12345679, GOLD_TS);
      run_check(1'b0, 0);
      set_cfg(3, 3, 1, 1, GOLD_ID, GOLD_TS);
      run_check(1'b0, 4);
      set_cfg(1, 2, 2, 3, pick_word(GOLD_ID), pick_word(GOLD_TS));
      run_check(1'b0, 0);
      set_cfg(0, 1, 2, 1, 32'hA5A5_0001, 32'h0BAD_F00D);
      reset_mid();

`ifdef SYSID_CHECKER_TIMEOUT_EN
      begin
         int nread, got;
         nread = 0;
         got   = -1;
         stuck = 1'b1;
         start = 1'b1;
         for (int t = 1; t <= 100; t++) begin
            step();
            start = 1'b0;
            if (avm_read) nread++;
            if (done) begin
               got = t;
               break;
            end
         end
         check_eq("to_read_cycles", nread, 8);
         check_eq("to_done_cycle", got, 9);
         check_eq("to_timeout", timeout, 1);
         check_eq("to_id_ok", id_ok, 0);
         check_eq("to_ts_ok", ts_ok, 0);
         stuck = 1'b0;
         $display("txn: stuck waitrequest, read held %0d cycles, done@%0d", nread, got);
      end
`endif

      for (int i = 0; i < 20; i++) begin
         s0 = $urandom_range(4);
         s1 = $urandom_range(4);
         l0 = $urandom_range(3, 1);
         l1 = $urandom_range(3, 1);
         set_cfg(s0, s1, l0, l1, pick_word(GOLD_ID), pick_word(GOLD_TS));
         exp_d = 3 + s0 + s1 + l0 + l1;
         ms = ($urandom_range(1) == 1) ? $urandom_range(exp_d - 1, 2) : 0;
         run_check(1'b0, ms);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
